mem_responder: RTL

MEM_RESPONDER -- requirements
Module: mem_responder

---
 rtl/mem_pkg.sv | 22 ++
 rtl/mem_array.sv | 40 ++++
 rtl/mem_responder.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/mem_pkg.sv
// Shared definitions for the memory responder: FSM states, transfer
// direction encodings, data width and the request address check.
package mem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic MEM_READ  = 1'b1;
    localparam logic MEM_WRITE = 1'b0;
    localparam int   MEM_DW    = 32;

    // A request is rejected when it is not word aligned or when its word
    // index falls outside the array. The full index is compared, so an
    // out-of-range address can never alias onto a low word.
    function automatic logic addr_is_bad(input logic [31:0] a, input int depth);
        return (a[1:0] != 2'b00) || ($unsigned(32'(a[31:2])) >= $unsigned(depth));
    endfunction

endpackage

// File: rtl/mem_array.sv
// Single-port word RAM, DEPTH x 32, synchronous write and registered read.
// The read register can be loaded with zero instead of the array word so the
// responder can answer a rejected read without a separate output register.
// The array itself is never reset; only the read register is.
module mem_array import mem_pkg::*; #(
    parameter int DEPTH = 256,
    parameter int IDX_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              we,
    input  logic              re,
    input  logic              rd_clr,
    input  logic [IDX_W-1:0]  idx,
    input  logic [MEM_DW-1:0] wdata,
    output logic [MEM_DW-1:0] rdata
);

    logic [MEM_DW-1:0] mem [DEPTH];
    logic [MEM_DW-1:0] rdata_q;

    // Write port: storage contents survive reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[idx] <= wdata;
        end
    end

    // Read register: loads only on a read response and holds otherwise.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rdata_q <= '0;
        end else if (re) begin
            rdata_q <= rd_clr ? '0 : mem[idx];
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/mem_responder.sv
// Memory responder for a multicycle controller/datapath. A request accepted
// in IDLE is answered with a one-cycle ready pulse after WAIT_CYCLES wait
// states. The wait states and their counter exist only when the macro
// MEM_WAIT_STATES_EN is defined; otherwise every response comes straight
// after acceptance and WAIT_CYCLES has no effect.
module mem_responder import mem_pkg::*; #(
    parameter int DEPTH       = 256,
    parameter int WAIT_CYCLES = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req,
    input  logic              r_wbar,
    input  logic [31:0]       addr,
    input  logic [MEM_DW-1:0] wdata,
    output logic [MEM_DW-1:0] rdata,
    output logic              ready,
    output logic              err
);

    localparam int IDX_W = $clog2(DEPTH);

`ifdef MEM_WAIT_STATES_EN
    localparam int EFF_WAIT = WAIT_CYCLES;
    localparam int CNT_W    = 4;
`else
    // Without wait states the configured count is irrelevant.
    localparam int EFF_WAIT = 0 * WAIT_CYCLES;
`endif

    state_t            state_q, state_d;
    logic [31:0]       addr_q, addr_d;
    logic [MEM_DW-1:0] wdata_q, wdata_d;
    logic              rw_q, rw_d;
    logic              ready_q, ready_d;
    logic              err_q, err_d;
`ifdef MEM_WAIT_STATES_EN
    logic [CNT_W-1:0]  cnt_q, cnt_d;
`endif

    logic [31:0]       cur_addr;
    logic [MEM_DW-1:0] cur_wdata;
    logic              cur_rw;
    logic              cur_bad;
    logic              resp_entry;
    logic              mem_we;
    logic              mem_re;

    // State register plus latched request and registered response flags.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            rw_q    <= 1'b0;
            ready_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rw_q    <= rw_d;
            ready_q <= ready_d;
            err_q   <= err_d;
        end
    end

`ifdef MEM_WAIT_STATES_EN
    // Wait-state down-counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`endif

    // Next state: accept in IDLE only, count down in WAIT, RESP lasts one cycle.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rw_d    = rw_q;
`ifdef MEM_WAIT_STATES_EN
        cnt_d   = cnt_q;
`endif
        case (state_q)
            IDLE: begin
                if (req) begin
                    addr_d  = addr;
                    wdata_d = wdata;
                    rw_d    = r_wbar;
                    if (EFF_WAIT == 0) begin
                        state_d = RESP;
                    end
`ifdef MEM_WAIT_STATES_EN
                    else begin
                        state_d = WAIT;
                        cnt_d   = CNT_W'(EFF_WAIT - 1);
                    end
`endif
                end
            end
`ifdef MEM_WAIT_STATES_EN
            WAIT: begin
                if (cnt_q == '0) begin
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
`endif
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs and memory strobes for the edge that enters RESP. With zero wait
    // states that edge is the acceptance edge itself, so the live request
    // inputs are used instead of the latched copy.
    always_comb begin
        cur_addr  = addr_q;
        cur_wdata = wdata_q;
        cur_rw    = rw_q;
        if (state_q == IDLE) begin
            cur_addr  = addr;
            cur_wdata = wdata;
            cur_rw    = r_wbar;
        end
        cur_bad    = addr_is_bad(cur_addr, DEPTH);
        resp_entry = (state_d == RESP);
        ready_d    = resp_entry;
        err_d      = resp_entry && cur_bad;
        mem_we     = resp_entry && !cur_bad && (cur_rw == MEM_WRITE);
        mem_re     = resp_entry && (cur_rw == MEM_READ);
    end

    mem_array #(
        .DEPTH (DEPTH),
        .IDX_W (IDX_W)
    ) u_mem_array (
        .clk    (clk),
        .reset  (reset),
        .we     (mem_we),
        .re     (mem_re),
        .rd_clr (cur_bad),
        .idx    (cur_addr[IDX_W+1:2]),
        .wdata  (cur_wdata),
        .rdata  (rdata)
    );

    assign ready = ready_q;
    assign err   = err_q;

endmodule
